oq_port_demux: RTL
==================

// Module: oq_port_demux
// PURPOSE
//  Consumer of the IOQ module-header dst-port bitmap written by the lookup stage.
//  Reads the one-hot/multi-hot dst field from the first (IOQ) header word of each packet.
//  Replicates every word of that packet onto a shared bus, with a per-queue write strobe.
//  Sits between the output port lookup stage and the per-port output queues.
// PARAMETERS
//  DATA_WIDTH         64              datapath word width
//  CTRL_WIDTH         DATA_WIDTH/8    ctrl width
//  NUM_OUTPUT_QUEUES  8               number of destination queues (<=16)
//  IO_QUEUE_STAGE_NUM 8'hff           ctrl value marking the IOQ module header word
//  IOQ_DST_PORT_POS   0               LSB of 16-bit dst-port bitmap in IOQ header word
// PORTS
//  clk           in   1                  clock
//  reset         in   1                  synchronous, active-low reset (asserted when 0)
//  in_data       in   DATA_WIDTH         input word
//  in_ctrl       in   CTRL_WIDTH         input ctrl (!=0 header/last word, 0 payload)
//  in_wr         in   1                  input word valid
//  in_rdy        out  1                  upstream may write (= !fifo nearly_full)
//  out_data      out  DATA_WIDTH         shared output word
//  out_ctrl      out  CTRL_WIDTH         shared output ctrl
//  out_wr        out  NUM_OUTPUT_QUEUES  per-queue write strobe
//  out_rdy       in   NUM_OUTPUT_QUEUES  per-queue ready (has >=1 word of slack)
//  pkt_fwd_cnt   out  32                 packets forwarded to >=1 queue
//  pkt_drop_cnt  out  32                 packets dropped (empty mask or no IOQ hdr)
// BEHAVIOUR
//  - Input buffer: small_fifo, depth 4; in_rdy = !nearly_full; writes ignored while reset=0.
//  - FSM: IDLE, HDRS, PAYLOAD; drop flag held for the packet.
//  - IDLE: the head word is the first word of the packet.
//    - If ctrl==IO_QUEUE_STAGE_NUM: mask = data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
//      bits above NUM_OUTPUT_QUEUES are ignored. drop = (mask==0).
//    - Otherwise: protocol error, so drop=1 and mask=0.
//    - Next state is HDRS after the pop.
//  - HDRS: pop of a word with ctrl==0 -> PAYLOAD.
//  - PAYLOAD: pop of a word with ctrl!=0 (last word) -> IDLE; counter updated on that pop.
//  - Pop condition: !empty && (drop || &(out_rdy | ~mask)).
//    All selected queues advance in lockstep; unselected queues never stall.
//  - Output registered, latency 1: out_data/out_ctrl <= head word on pop.
//    out_wr <= (pop && !drop) ? mask : 0.
//    The mask for the first word is the one decoded from that same word (combinational bypass).
//  - Dropped packets: all words are popped at 1/cycle; out_wr stays 0.
//  - Counters: pkt_fwd_cnt++ on last-word pop when !drop, else pkt_drop_cnt++.
//    Counters wrap 2^32-1 -> 0.
//  - Reset (reset==0): state=IDLE, mask=0, drop=0, fifo flushed, out_wr=0, out_data=0,
//    out_ctrl=0, counters=0, in_rdy=0.
//    Reset mid-packet truncates the packet (no recovery words are sent).
//    The first word after reset is treated as a new packet.
//  - Back-to-back packets: the last word of pkt N and the IOQ word of pkt N+1 may pop
//    on consecutive cycles with no bubble.
//  - out_rdy deasserted on any selected queue freezes the pop. out_data holds its value;
//    out_wr goes to 0 the following cycle.
// STRUCTURE
//  - IO_QUEUE_STAGE_NUM and IOQ_DST_PORT_POS come from the shared NetFPGA defines header;
//    they are not redefined locally.
//  - The only sub-module is the existing small_fifo (WIDTH=CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=2).
//  - FSM, pop logic and counters stay inline.
// TESTING
//  1. IOQ hdr with dst=16'h0004, 1 payload word (ctrl 0), last word (ctrl 8'h80),
//     all out_rdy=1 -> 3 words appear with out_wr=8'h04, 1 cycle after each pop;
//     pkt_fwd_cnt=1.
//  2. dst=16'h0055 (broadcast to MACs), out_rdy=8'hFB for 5 cycles then 8'hFF ->
//     no out_wr during the stall; then every word is emitted with out_wr=8'h55;
//     in_rdy drops once 3 words are buffered.
//  3. dst=16'h0000, 4-word packet -> out_wr never set; pkt_drop_cnt=1;
//     the next packet (dst=16'h0001) is forwarded with no lost words.
//  4. First word ctrl=8'h00 (no IOQ hdr) -> whole packet dropped to its last word;
//     pkt_drop_cnt=1.
//  5. dst=16'hFF02 with NUM_OUTPUT_QUEUES=8 -> out_wr=8'h02 only; out_rdy[7:2]=0
//     does not stall.
//  6. Assert reset=0 after 2 words of a packet, release, send a fresh packet with dst=16'h0008
//     -> outputs and counters are 0 during reset; the fresh packet is emitted intact
//     with out_wr=8'h08.

Source files
------------

// File: rtl/oq_port_demux_pkg.sv
// rtl/oq_port_demux_pkg.sv - shared IOQ header constants and demux FSM state type
// Contents:
//   IO_QUEUE_STAGE_NUM  ctrl value that marks the IOQ module header word
//   IOQ_DST_PORT_POS    LSB of the 16-bit dst-port bitmap inside the IOQ header word
//   state_e             packet-walk FSM states
package oq_port_demux_pkg;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
  localparam int         IOQ_DST_PORT_POS   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDRS    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/oq_port_demux_small_fifo.sv
// rtl/oq_port_demux_small_fifo.sv - fall-through input buffer for the port demux
// Ports:
//   clk, resetn        clock, synchronous active-low reset (flushes contents)
//   din, wr_en         write word and strobe (ignored when full)
//   rd_en, dout        pop strobe (ignored when empty); dout shows the head word
//   full, nearly_full  no free slot / at most one free slot
//   empty              no word stored
module small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      do_wr, do_rd;

  assign full        = (count_q == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign nearly_full = (count_q >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  assign empty       = (count_q == '0);
  assign dout        = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + MAX_DEPTH_BITS'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + MAX_DEPTH_BITS'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (MAX_DEPTH_BITS+1)'(1);
      2'b01:   count_d = count_q - (MAX_DEPTH_BITS+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/oq_port_demux.sv
// rtl/oq_port_demux.sv - replicate packets onto a shared bus with per-queue write strobes
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   in_data/in_ctrl/in_wr    input word stream; in_rdy = buffer has room
//   out_data/out_ctrl        shared output word, registered
//   out_wr[NUM_OUTPUT_QUEUES] per-queue write strobe; out_rdy per-queue ready
//   pkt_fwd_cnt              packets sent to at least one queue
//   pkt_drop_cnt             packets discarded (empty dst mask or missing IOQ header)
module oq_port_demux
  import oq_port_demux_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic [31:0]                  pkt_fwd_cnt,
  output logic [31:0]                  pkt_drop_cnt
);

  localparam int FIFO_WIDTH = CTRL_WIDTH + DATA_WIDTH;

  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_full, fifo_nearly_full, fifo_empty, fifo_wr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  state_e                       state_q, state_d;
  logic [NUM_OUTPUT_QUEUES-1:0] mask_q, mask_d;
  logic                         drop_q, drop_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]        out_ctrl_q, out_ctrl_d;
  logic [NUM_OUTPUT_QUEUES-1:0] out_wr_q, out_wr_d;
  logic [31:0]                  fwd_cnt_q, fwd_cnt_d;
  logic [31:0]                  drop_cnt_q, drop_cnt_d;

  logic                         is_ioq;
  logic [NUM_OUTPUT_QUEUES-1:0] dec_mask, cur_mask;
  logic                         cur_drop, pop;

  // Writes are blocked during reset so the buffer comes out of reset empty.
  assign fifo_wr = in_wr && reset && !fifo_full;
  assign in_rdy  = reset && !fifo_nearly_full;

  small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (2)
  ) u_in_fifo (
    .clk         (clk),
    .resetn      (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (fifo_wr),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign head_ctrl = fifo_dout[FIFO_WIDTH-1 -: CTRL_WIDTH];
  assign head_data = fifo_dout[DATA_WIDTH-1:0];

  // In IDLE the head word is the packet's first word, so its own dst bitmap
  // steers it; afterwards the latched mask/drop apply to the rest of the packet.
  always_comb begin
    is_ioq   = (head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    dec_mask = is_ioq ? head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] : '0;
    cur_mask = (state_q == ST_IDLE) ? dec_mask : mask_q;
    cur_drop = (state_q == ST_IDLE) ? (dec_mask == '0) : drop_q;
    // Only selected queues can stall; a dropped packet drains at full rate.
    pop      = !fifo_empty && (cur_drop || (&(out_rdy | ~cur_mask)));
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    drop_d     = drop_q;
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    out_wr_d   = '0;

    if (pop) begin
      out_data_d = head_data;
      out_ctrl_d = head_ctrl;
      if (!cur_drop) out_wr_d = cur_mask;
    end

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_HDRS;
          mask_d  = dec_mask;
          drop_d  = (dec_mask == '0);
        end
      end
      ST_HDRS: begin
        if (pop && (head_ctrl == '0)) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (pop && (head_ctrl != '0)) begin
          state_d = ST_IDLE;
          if (drop_q) drop_cnt_d = drop_cnt_q + 32'd1;
          else        fwd_cnt_d  = fwd_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      drop_q     <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      drop_q     <= drop_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q   <= out_wr_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_ctrl     = out_ctrl_q;
  assign out_wr       = out_wr_q;
  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule
